// File: rtl/msrh_sched_pick_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : msrh_sched_pick_ctrl_if
// Description : Dispatch-allocation and issue-pick signal bundle shared by the
//               scheduler pick controller and its dispatch/issue neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface msrh_sched_pick_ctrl_if #(
  parameter int ENTRY_SIZE = 8,
  parameter int IDX_W      = $clog2(ENTRY_SIZE)
);
  logic                  i_alloc_req;
  logic                  o_alloc_ready;
  logic [ENTRY_SIZE-1:0] o_alloc_oh;
  logic [IDX_W-1:0]      o_alloc_idx;
  logic [ENTRY_SIZE-1:0] i_entry_ready;
  logic [ENTRY_SIZE-1:0] i_entry_finish;
  logic                  i_pick_stall;
  logic [ENTRY_SIZE-1:0] o_entry_picked;
  logic                  o_pick_valid;
  logic [IDX_W-1:0]      o_pick_idx;
  logic [IDX_W:0]        o_free_cnt;

  // Driver side: dispatch, entries and issue pipe.
  modport master (
    output i_alloc_req, i_entry_ready, i_entry_finish, i_pick_stall,
    input  o_alloc_ready, o_alloc_oh, o_alloc_idx, o_entry_picked,
           o_pick_valid, o_pick_idx, o_free_cnt
  );

  // Controller side.
  modport slave (
    input  i_alloc_req, i_entry_ready, i_entry_finish, i_pick_stall,
    output o_alloc_ready, o_alloc_oh, o_alloc_idx, o_entry_picked,
           o_pick_valid, o_pick_idx, o_free_cnt
  );
endinterface
`default_nettype wire

// File: rtl/msrh_sched_pick_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : msrh_sched_pick_ctrl
// Description : Scheduler entry allocator plus oldest-first issue picker.
//               Tracks free entries and a relative-age matrix
//               (r_age[i][j]=1 means entry i is older than entry j).
// Revision    : 1.0 - initial release
// ============================================================================
module msrh_sched_pick_ctrl #(
  parameter int ENTRY_SIZE = 8,
  parameter int IDX_W      = $clog2(ENTRY_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  msrh_sched_pick_ctrl_if.slave bus
);

  localparam logic [IDX_W:0] c_entry_cnt = (IDX_W+1)'(ENTRY_SIZE);

  logic [ENTRY_SIZE-1:0]                 r_free;
  logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] r_age;
  logic [IDX_W:0]                        r_free_cnt;

  logic                  w_alloc_ready;
  logic [ENTRY_SIZE-1:0] w_alloc_lowest;
  logic [ENTRY_SIZE-1:0] w_alloc_oh;
  logic                  w_alloc_grant;
  logic [ENTRY_SIZE-1:0] w_fin_valid;
  logic [IDX_W:0]        w_fin_cnt;
  logic [ENTRY_SIZE-1:0] w_cand;
  logic [ENTRY_SIZE-1:0] w_blocked;
  logic [ENTRY_SIZE-1:0] w_pick;
  logic [IDX_W-1:0]      w_alloc_idx;
  logic [IDX_W-1:0]      w_pick_idx;

  // A finishing entry is still occupied this cycle, so the lowest free bit
  // can never be an entry that is finishing right now.
  assign w_alloc_ready  = |r_free;
  assign w_alloc_lowest = r_free & (~r_free + ENTRY_SIZE'(1));
  assign w_alloc_oh     = (bus.i_alloc_req && w_alloc_ready) ? w_alloc_lowest : '0;
  assign w_alloc_grant  = |w_alloc_oh;
  assign w_fin_valid    = bus.i_entry_finish & ~r_free;
  assign w_cand         = bus.i_entry_ready & ~r_free;

  // Oldest-first pick: an entry is blocked if any older candidate exists.
  always_comb begin
    w_blocked = '0;
    w_pick    = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      for (int j = 0; j < ENTRY_SIZE; j++) begin
        w_blocked[i] = w_blocked[i] | (w_cand[j] & r_age[j][i]);
      end
      w_pick[i] = w_cand[i] & ~w_blocked[i] & ~bus.i_pick_stall;
    end
  end

  // One-hot to binary encoders and count of genuine releases.
  always_comb begin
    w_alloc_idx = '0;
    w_pick_idx  = '0;
    w_fin_cnt   = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      if (w_alloc_oh[i]) w_alloc_idx = w_alloc_idx | IDX_W'(i);
      if (w_pick[i])     w_pick_idx  = w_pick_idx | IDX_W'(i);
      w_fin_cnt = w_fin_cnt + (IDX_W+1)'(w_fin_valid[i]);
    end
  end

  // Free vector, age matrix and free counter update.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_free     <= '1;
      r_age      <= '0;
      r_free_cnt <= c_entry_cnt;
    end else begin
      r_free     <= (r_free & ~w_alloc_oh) | w_fin_valid;
      r_free_cnt <= r_free_cnt + w_fin_cnt - (IDX_W+1)'(w_alloc_grant);
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        for (int j = 0; j < ENTRY_SIZE; j++) begin
          if (i == j || w_fin_valid[i] || w_fin_valid[j]) begin
            r_age[i][j] <= 1'b0;
          end else if (w_alloc_oh[j]) begin
            // Every entry already resident is older than the new one.
            r_age[i][j] <= ~r_free[i];
          end else if (w_alloc_oh[i]) begin
            r_age[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.o_alloc_ready  = w_alloc_ready;
  assign bus.o_alloc_oh     = w_alloc_oh;
  assign bus.o_alloc_idx    = w_alloc_idx;
  assign bus.o_entry_picked = w_pick;
  assign bus.o_pick_valid   = |w_pick;
  assign bus.o_pick_idx     = w_pick_idx;
  assign bus.o_free_cnt     = r_free_cnt;

endmodule
`default_nettype wire

// File: tb/tb_msrh_sched_pick_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrh_sched_pick_ctrl
// Description : Scoreboard bench for msrh_sched_pick_ctrl (ENTRY_SIZE=8).
//               Directed vectors followed by a random phase checked against
//               an age-ordered list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrh_sched_pick_ctrl;

  localparam int E = 8;

  typedef struct {
    logic       ar;
    logic [7:0] aoh;
    logic [2:0] aidx;
    logic       pv;
    logic [7:0] poh;
    logic [2:0] pidx;
    logic [3:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  exp_t cur;

  msrh_sched_pick_ctrl_if #(.ENTRY_SIZE(E)) bus ();

  msrh_sched_pick_ctrl #(.ENTRY_SIZE(E)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] enc(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < E; i++) if (oh[i]) r = r | 3'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected during it.
  task automatic v(input logic a, input logic [7:0] rdy, input logic [7:0] fin,
                   input logic st, input logic ear, input logic [7:0] eaoh,
                   input logic [7:0] epoh, input logic [3:0] ecnt,
                   input logic rn = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n              = rn;
    bus.i_alloc_req    = a;
    bus.i_entry_ready  = rdy;
    bus.i_entry_finish = fin;
    bus.i_pick_stall   = st;
    e.ar   = ear;
    e.aoh  = eaoh;
    e.aidx = enc(eaoh);
    e.pv   = |epoh;
    e.poh  = epoh;
    e.pidx = enc(epoh);
    e.cnt  = ecnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs mid-cycle against the queued response.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("alloc_ready", 32'(bus.o_alloc_ready),  32'(cur.ar));
      chk("alloc_oh",    32'(bus.o_alloc_oh),     32'(cur.aoh));
      chk("alloc_idx",   32'(bus.o_alloc_idx),    32'(cur.aidx));
      chk("pick_valid",  32'(bus.o_pick_valid),   32'(cur.pv));
      chk("entry_picked",32'(bus.o_entry_picked), 32'(cur.poh));
      chk("pick_idx",    32'(bus.o_pick_idx),     32'(cur.pidx));
      chk("free_cnt",    32'(bus.o_free_cnt),     32'(cur.cnt));
    end
  end

  int         age_q[$];
  int         nq[$];
  logic [7:0] mfree;

  initial begin
    checks             = 0;
    failures           = 0;
    rst_n              = 1'b0;
    bus.i_alloc_req    = 1'b0;
    bus.i_entry_ready  = '0;
    bus.i_entry_finish = '0;
    bus.i_pick_stall   = 1'b0;

    // Reset: idle, then alloc/finish/ready presented while reset is held.
    v(0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 4'd8, 1'b0);
    v(1, 8'hFF, 8'hFF, 0, 1, 8'h01, 8'h00, 4'd8, 1'b0);

    // Fill the table in index order, then one request with nothing free.
    for (int k = 0; k < E; k++) v(1, 8'h00, 8'h00, 0, 1, 8'(1) << k, 8'h00, 4'(8 - k));
    v(1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'd0);

    // Oldest-first picks on a full table and stall masking.
    v(0, 8'hA0, 8'h00, 0, 0, 8'h00, 8'h20, 4'd0);
    v(0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h01, 4'd0);
    v(0, 8'h10, 8'h00, 1, 0, 8'h00, 8'h00, 4'd0);
    v(0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h10, 4'd0);

    // Finish 4 while requesting: no grant now, grant of 4 next cycle.
    v(1, 8'h00, 8'h10, 0, 0, 8'h00, 8'h00, 4'd0);
    v(1, 8'h00, 8'h00, 0, 1, 8'h10, 8'h00, 4'd1);
    v(0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h01, 4'd0);
    v(0, 8'h18, 8'h00, 0, 0, 8'h00, 8'h08, 4'd0);
    v(0, 8'h90, 8'h00, 0, 0, 8'h00, 8'h80, 4'd0);

    // Reallocate 3, then 1, then 5 (finish+alloc in one cycle), free others.
    v(0, 8'h00, 8'h08, 0, 0, 8'h00, 8'h00, 4'd0);
    v(1, 8'h00, 8'h02, 0, 1, 8'h08, 8'h00, 4'd1);
    v(1, 8'h00, 8'h20, 0, 1, 8'h02, 8'h00, 4'd1);
    v(1, 8'h00, 8'h00, 0, 1, 8'h20, 8'h00, 4'd1);
    v(0, 8'h00, 8'hD5, 0, 0, 8'h00, 8'h00, 4'd0);
    v(0, 8'hFF, 8'h00, 0, 1, 8'h00, 8'h08, 4'd5);
    v(0, 8'hFF, 8'h08, 0, 1, 8'h00, 8'h08, 4'd5);
    v(0, 8'hFF, 8'h00, 0, 1, 8'h00, 8'h02, 4'd6);
    v(0, 8'hFF, 8'h02, 0, 1, 8'h00, 8'h02, 4'd6);
    v(0, 8'hFF, 8'h00, 0, 1, 8'h00, 8'h20, 4'd7);
    v(0, 8'hFF, 8'h01, 0, 1, 8'h00, 8'h20, 4'd7);
    v(0, 8'h00, 8'h20, 0, 1, 8'h00, 8'h00, 4'd7);
    v(0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 4'd8);

    // Entry allocated with ready asserted is picked only the next cycle.
    v(1, 8'h01, 8'h00, 0, 1, 8'h01, 8'h00, 4'd8);
    v(0, 8'h01, 8'h00, 0, 1, 8'h00, 8'h01, 4'd7);
    v(0, 8'h00, 8'h01, 0, 1, 8'h00, 8'h00, 4'd7);
    v(0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 4'd8);

    // Random traffic checked against an age-ordered list of resident entries.
    mfree = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      logic       a, st, ear, found;
      logic [7:0] rdy, fin, eaoh, epoh, vfin;
      a     = 1'($urandom_range(0, 1));
      rdy   = 8'($urandom);
      fin   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      st    = ($urandom_range(0, 7) == 0);
      ear   = |mfree;
      eaoh  = '0;
      found = 1'b0;
      if (a && ear) begin
        for (int i = 0; i < E; i++) begin
          if (mfree[i] && !found) begin
            eaoh  = 8'(1) << i;
            found = 1'b1;
          end
        end
      end
      epoh  = '0;
      found = 1'b0;
      if (!st) begin
        foreach (age_q[n]) begin
          if (rdy[age_q[n]] && !found) begin
            epoh  = 8'(1) << age_q[n];
            found = 1'b1;
          end
        end
      end
      v(a, rdy, fin, st, ear, eaoh, epoh, 4'($countones(mfree)));
      vfin = fin & ~mfree;
      nq.delete();
      foreach (age_q[n]) if (!vfin[age_q[n]]) nq.push_back(age_q[n]);
      age_q = nq;
      for (int i = 0; i < E; i++) if (eaoh[i]) age_q.push_back(i);
      mfree = (mfree & ~eaoh) | vfin;
    end

    @(posedge clk);
    #1;
    bus.i_alloc_req    = 1'b0;
    bus.i_entry_ready  = '0;
    bus.i_entry_finish = '0;
    bus.i_pick_stall   = 1'b0;
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
